stopwatch_input_conditioner: RTL and testbench

- Conditions the raw Basys3 push-buttons and slide switches for the stopwatch.
- Sits directly upstream of the time counter.
- Every asynchronous pad input is synchronized into the 100 MHz `clk` domain; buttons are also debounced.
- Outputs are clean levels, single-cycle press/release pulses, a clear strobe and a pause/run toggle state, all synchronous to `clk`.

---
 rtl/stopwatch_input_conditioner_if.sv | 37 +++
 rtl/stopwatch_input_conditioner.sv | 91 +++++++++
 tb/tb_stopwatch_input_conditioner.sv | 132 +++++++++++++
 3 files changed

// File: rtl/stopwatch_input_conditioner_if.sv
// Pad-side and conditioned-side signals of the stopwatch input conditioner.
// The slave modport belongs to the conditioner; the master modport belongs to whoever drives the pads.
interface stopwatch_input_conditioner_if #(
    parameter int N_BTN = 2,
    parameter int N_SW  = 2
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_SW-1:0]  sw_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_SW-1:0]  sw_level;
    logic             clear_pulse;
    logic             paused;

    modport master (
        output btn_raw,
        output sw_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  sw_level,
        input  clear_pulse,
        input  paused
    );

    modport slave (
        input  btn_raw,
        input  sw_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output sw_level,
        output clear_pulse,
        output paused
    );
endinterface

// File: rtl/stopwatch_input_conditioner.sv
// Synchronizes and debounces the Basys3 buttons and switches for the stopwatch.
// It also keeps the pause/run toggle that the time counter consumes.
module stopwatch_input_conditioner #(
    parameter int N_BTN           = 2,
    parameter int N_SW            = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20,
    parameter int CLEAR_IDX       = 0,
    parameter int PAUSE_IDX       = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    stopwatch_input_conditioner_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] btn_s1_q, btn_s2_q;
    logic [N_SW-1:0]  sw_s1_q, sw_s2_q;
    logic [N_BTN-1:0] stable_q, stable_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic             paused_q, paused_d;

    // The counter only advances while the synchronized input disagrees with the stable level,
    // so it saturates at the compare value instead of wrapping.
    always_comb begin
        stable_d  = stable_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (btn_s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] < CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end else begin
                    stable_d[i]  = btn_s2_q[i];
                    press_d[i]   = btn_s2_q[i];
                    release_d[i] = ~btn_s2_q[i];
                end
            end
        end

        // A clear press wins over a pause press that lands on the same cycle.
        if (press_q[CLEAR_IDX]) begin
            paused_d = 1'b0;
        end else if (press_q[PAUSE_IDX]) begin
            paused_d = ~paused_q;
        end else begin
            paused_d = paused_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q  <= '0;
            btn_s2_q  <= '0;
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            paused_q  <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            btn_s1_q  <= bus.btn_raw;
            btn_s2_q  <= btn_s1_q;
            sw_s1_q   <= bus.sw_raw;
            sw_s2_q   <= sw_s1_q;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            paused_q  <= paused_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.btn_level   = stable_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.sw_level    = sw_s2_q;
    assign bus.clear_pulse = press_q[CLEAR_IDX];
    assign bus.paused      = paused_q;

endmodule

// File: tb/tb_stopwatch_input_conditioner.sv
// Directed bench for the stopwatch input conditioner with a 4-cycle debounce window.
// Expected values are hand-derived from the 2-edge sync plus 4-cycle debounce timing.
module tb_stopwatch_input_conditioner;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    stopwatch_input_conditioner_if #(.N_BTN(2), .N_SW(2)) bus ();

    stopwatch_input_conditioner #(
        .N_BTN(2),
        .N_SW(2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3),
        .CLEAR_IDX(0),
        .PAUSE_IDX(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives the buttons, then checks every cycle: the new level and pulses appear on edge 6,
    // paused follows one edge later, and the switch level settles after edge 2.
    task automatic applyStimulus(input string tag, input logic [1:0] raw,
                                 input logic [1:0] levelBefore, input logic [1:0] levelAfter,
                                 input logic [1:0] pressExp, input logic [1:0] releaseExp,
                                 input logic pausedBefore, input logic pausedAfter,
                                 input logic [1:0] swBefore, input logic [1:0] swAfter,
                                 input int cycles);
        bus.btn_raw = raw;
        for (int k = 1; k <= cycles; k++) begin
            step();
            checkOutput({tag, "_level"},   32'(bus.btn_level),   32'(k >= 6 ? levelAfter : levelBefore));
            checkOutput({tag, "_press"},   32'(bus.btn_press),   32'(k == 6 ? pressExp : 2'b00));
            checkOutput({tag, "_release"}, 32'(bus.btn_release), 32'(k == 6 ? releaseExp : 2'b00));
            checkOutput({tag, "_clear"},   32'(bus.clear_pulse), 32'(k == 6 ? pressExp[0] : 1'b0));
            checkOutput({tag, "_paused"},  32'(bus.paused),      32'(k >= 7 ? pausedAfter : pausedBefore));
            checkOutput({tag, "_sw"},      32'(bus.sw_level),    32'(k >= 2 ? swAfter : swBefore));
        end
    endtask

    initial begin
        logic [4:0] bounce;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.btn_raw = 2'b11;
        bus.sw_raw  = 2'b11;

        // Reset with every pad high: all outputs held at zero.
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput("reset_outputs",
                        32'({bus.btn_level, bus.btn_press, bus.btn_release, bus.sw_level,
                             bus.clear_pulse, bus.paused}), 32'd0);
        end
        rst_n = 1'b1;
        applyStimulus("reset_release", 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 8);
        applyStimulus("release_both", 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 2'b11, 2'b11, 8);

        // Switch change lands two edges later; a 3-cycle button glitch is swallowed.
        bus.sw_raw     = 2'b01;
        bus.btn_raw[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) bus.btn_raw[1] = 1'b0;
            step();
            checkOutput("glitch_sw", 32'(bus.sw_level), 32'(k >= 2 ? 2'b01 : 2'b11));
            checkOutput("glitch_quiet", 32'({bus.btn_level, bus.btn_press, bus.paused}), 32'd0);
        end

        // Pause toggles on each press, with exactly one pulse per press and per release.
        applyStimulus("pause_on",   2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b1, 2'b01, 2'b01, 10);
        applyStimulus("pause_rel1", 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 2'b01, 2'b01, 10);
        applyStimulus("pause_off",  2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 2'b01, 2'b01, 10);
        applyStimulus("pause_rel2", 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 2'b01, 2'b01, 10);

        // Clear and pause pressed together while paused: clear wins.
        applyStimulus("prep_pause", 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b1, 2'b01, 2'b01, 10);
        applyStimulus("prep_rel",   2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 2'b01, 2'b01, 10);
        applyStimulus("clear_prio", 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 2'b01, 10);
        applyStimulus("clear_rel",  2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 2'b01, 2'b01, 10);

        // Bouncy edge 1,0,1,0,1 then held: single clear on edge 10 (6 edges after the last rise).
        bounce = 5'b10101;
        for (int k = 1; k <= 14; k++) begin
            bus.btn_raw[0] = (k <= 5) ? bounce[k-1] : 1'b1;
            step();
            checkOutput("bounce_clear", 32'(bus.clear_pulse), 32'(k == 10));
            checkOutput("bounce_level", 32'(bus.btn_level), 32'(k >= 10 ? 2'b01 : 2'b00));
        end
        applyStimulus("bounce_rel", 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 10);

        // Reset part-way through a count; the held button needs the full latency again.
        bus.btn_raw = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            step();
            checkOutput("midcnt_pre", 32'({bus.btn_level, bus.btn_press}), 32'd0);
        end
        rst_n = 1'b0;
        step();
        checkOutput("midcnt_reset",
                    32'({bus.btn_level, bus.btn_press, bus.btn_release, bus.sw_level,
                         bus.clear_pulse, bus.paused}), 32'd0);
        rst_n = 1'b1;
        applyStimulus("midcnt_after", 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
